// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - 8-line interrupt controller with edge latching and nested in-service tracking
// Produces one-hot next-request (min_bit_s) and active-level (min_bit_a) vectors for the control unit.
module intr_ctrl #(
  parameter int N_IRQ = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             s_intr,
  input  logic [N_IRQ-1:0] s_call_intr,
  input  logic [N_IRQ-1:0] s_return_intr,
  input  logic             lost_clr,
  output logic [N_IRQ-1:0] min_bit_s,
  output logic [N_IRQ-1:0] min_bit_a,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] in_service,
  output logic [N_IRQ-1:0] irq_lost
);

  localparam logic [N_IRQ-1:0] ONE = {{(N_IRQ-1){1'b0}}, 1'b1};

  logic [N_IRQ-1:0] r_sync1;
  logic [N_IRQ-1:0] r_sync2;
  logic [N_IRQ-1:0] r_sync2_d;
  logic [N_IRQ-1:0] r_pending;
  logic [N_IRQ-1:0] r_in_service;
  logic [N_IRQ-1:0] r_irq_lost;

  logic [N_IRQ-1:0] w_edge;
  logic [N_IRQ-1:0] w_ack;
  logic [N_IRQ-1:0] w_ret;
  logic [N_IRQ-1:0] w_req;

  assign w_edge = r_sync2 & ~r_sync2_d;
  assign w_ack  = s_intr ? s_call_intr   : '0;
  assign w_ret  = s_intr ? s_return_intr : '0;

  // Lowest set bit wins: bit 0 is the most urgent line.
  assign w_req     = r_pending & irq_mask & ~r_in_service;
  assign min_bit_s = w_req & (~w_req + ONE);
  assign min_bit_a = r_in_service & (~r_in_service + ONE);

  assign pending    = r_pending;
  assign in_service = r_in_service;
  assign irq_lost   = r_irq_lost;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_sync2_d    <= '0;
      r_pending    <= '0;
      r_in_service <= '0;
      r_irq_lost   <= '0;
    end else begin
      r_sync1      <= irq_in;
      r_sync2      <= r_sync1;
      r_sync2_d    <= r_sync2;
      // A fresh edge re-arms a line even while it is being acknowledged.
      r_pending    <= (r_pending & ~w_ack) | w_edge;
      r_in_service <= (r_in_service & ~w_ret) | w_ack;
      r_irq_lost   <= lost_clr ? '0 : (r_irq_lost | (w_edge & r_pending & ~w_ack));
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - directed self-checking bench for intr_ctrl
module tb_intr_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] irq_in;
  logic [7:0] irq_mask;
  logic       s_intr;
  logic [7:0] s_call_intr;
  logic [7:0] s_return_intr;
  logic       lost_clr;
  logic [7:0] min_bit_s;
  logic [7:0] min_bit_a;
  logic [7:0] pending;
  logic [7:0] in_service;
  logic [7:0] irq_lost;

  int n_checks;
  int n_fail;

  intr_ctrl #(.N_IRQ(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .irq_in        (irq_in),
    .irq_mask      (irq_mask),
    .s_intr        (s_intr),
    .s_call_intr   (s_call_intr),
    .s_return_intr (s_return_intr),
    .lost_clr      (lost_clr),
    .min_bit_s     (min_bit_s),
    .min_bit_a     (min_bit_a),
    .pending       (pending),
    .in_service    (in_service),
    .irq_lost      (irq_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ctrl(input logic [7:0] call, input logic [7:0] ret);
    s_intr = 1'b1; s_call_intr = call; s_return_intr = ret;
    cycles(1);
    s_intr = 1'b0; s_call_intr = 8'h00; s_return_intr = 8'h00;
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (pending !== 8'h00) begin n_fail++; $display("FAIL rst_pending got=%h exp=%h", pending, 8'h00); end
    n_checks++; if (in_service !== 8'h00) begin n_fail++; $display("FAIL rst_in_service got=%h exp=%h", in_service, 8'h00); end
    n_checks++; if (irq_lost !== 8'h00) begin n_fail++; $display("FAIL rst_irq_lost got=%h exp=%h", irq_lost, 8'h00); end
    n_checks++; if (min_bit_s !== 8'h00) begin n_fail++; $display("FAIL rst_min_bit_s got=%h exp=%h", min_bit_s, 8'h00); end
    n_checks++; if (min_bit_a !== 8'h00) begin n_fail++; $display("FAIL rst_min_bit_a got=%h exp=%h", min_bit_a, 8'h00); end
  endtask

  task automatic test_latency();
    @(negedge clk);
    irq_in = 8'h04;
    reset  = 1'b1;
    cycles(1);
    n_checks++; if (pending !== 8'h00) begin n_fail++; $display("FAIL lat_edge1 got=%h exp=%h", pending, 8'h00); end
    cycles(1);
    n_checks++; if (pending !== 8'h00) begin n_fail++; $display("FAIL lat_edge2 got=%h exp=%h", pending, 8'h00); end
    cycles(1);
    n_checks++; if (pending !== 8'h04) begin n_fail++; $display("FAIL lat_edge3_pending got=%h exp=%h", pending, 8'h04); end
    n_checks++; if (min_bit_s !== 8'h04) begin n_fail++; $display("FAIL lat_edge3_min_s got=%h exp=%h", min_bit_s, 8'h04); end
    cycles(10);
    n_checks++; if (pending !== 8'h04) begin n_fail++; $display("FAIL lat_hold_pending got=%h exp=%h", pending, 8'h04); end
    n_checks++; if (irq_lost !== 8'h00) begin n_fail++; $display("FAIL lat_hold_lost got=%h exp=%h", irq_lost, 8'h00); end
  endtask

  task automatic test_ack();
    pulse_ctrl(8'h04, 8'h00);
    n_checks++; if (pending !== 8'h00) begin n_fail++; $display("FAIL ack_pending got=%h exp=%h", pending, 8'h00); end
    n_checks++; if (in_service !== 8'h04) begin n_fail++; $display("FAIL ack_in_service got=%h exp=%h", in_service, 8'h04); end
    n_checks++; if (min_bit_a !== 8'h04) begin n_fail++; $display("FAIL ack_min_a got=%h exp=%h", min_bit_a, 8'h04); end
    n_checks++; if (min_bit_s !== 8'h00) begin n_fail++; $display("FAIL ack_min_s got=%h exp=%h", min_bit_s, 8'h00); end
    cycles(4);
    n_checks++; if (pending !== 8'h00) begin n_fail++; $display("FAIL ack_level_no_rerequest got=%h exp=%h", pending, 8'h00); end
    irq_in = 8'h00;
    cycles(2);
  endtask

  task automatic test_nesting();
    irq_in = 8'h01;
    cycles(3);
    irq_in = 8'h00;
    n_checks++; if (min_bit_s !== 8'h01) begin n_fail++; $display("FAIL nest_min_s got=%h exp=%h", min_bit_s, 8'h01); end
    pulse_ctrl(8'h01, 8'h00);
    n_checks++; if (in_service !== 8'h05) begin n_fail++; $display("FAIL nest_in_service got=%h exp=%h", in_service, 8'h05); end
    n_checks++; if (min_bit_a !== 8'h01) begin n_fail++; $display("FAIL nest_min_a_inner got=%h exp=%h", min_bit_a, 8'h01); end
    pulse_ctrl(8'h00, 8'h01);
    n_checks++; if (min_bit_a !== 8'h04) begin n_fail++; $display("FAIL nest_min_a_outer got=%h exp=%h", min_bit_a, 8'h04); end
    pulse_ctrl(8'h00, 8'h04);
    n_checks++; if (min_bit_a !== 8'h00) begin n_fail++; $display("FAIL nest_min_a_idle got=%h exp=%h", min_bit_a, 8'h00); end
    n_checks++; if (in_service !== 8'h00) begin n_fail++; $display("FAIL nest_in_service_idle got=%h exp=%h", in_service, 8'h00); end
    pulse_ctrl(8'h00, 8'h40);
    n_checks++; if (in_service !== 8'h00) begin n_fail++; $display("FAIL nest_ret_not_in_service got=%h exp=%h", in_service, 8'h00); end
  endtask

  task automatic test_mask();
    irq_mask = 8'hFE;
    irq_in   = 8'h01;
    cycles(3);
    irq_in = 8'h00;
    n_checks++; if (pending !== 8'h01) begin n_fail++; $display("FAIL mask_pending got=%h exp=%h", pending, 8'h01); end
    n_checks++; if (min_bit_s !== 8'h00) begin n_fail++; $display("FAIL mask_min_s_masked got=%h exp=%h", min_bit_s, 8'h00); end
    irq_mask = 8'hFF;
    #1;
    n_checks++; if (min_bit_s !== 8'h01) begin n_fail++; $display("FAIL mask_min_s_unmasked got=%h exp=%h", min_bit_s, 8'h01); end
    pulse_ctrl(8'h01, 8'h00);
    pulse_ctrl(8'h00, 8'h01);
    n_checks++; if (in_service !== 8'h00) begin n_fail++; $display("FAIL mask_cleanup got=%h exp=%h", in_service, 8'h00); end
  endtask

  task automatic test_lost();
    irq_in = 8'h08;
    cycles(3);
    n_checks++; if (pending !== 8'h08) begin n_fail++; $display("FAIL lost_first_pending got=%h exp=%h", pending, 8'h08); end
    irq_in = 8'h00;
    cycles(2);
    irq_in = 8'h08;
    cycles(3);
    n_checks++; if (irq_lost !== 8'h08) begin n_fail++; $display("FAIL lost_set got=%h exp=%h", irq_lost, 8'h08); end
    n_checks++; if (pending !== 8'h08) begin n_fail++; $display("FAIL lost_pending got=%h exp=%h", pending, 8'h08); end
    lost_clr = 1'b1;
    cycles(1);
    lost_clr = 1'b0;
    n_checks++; if (irq_lost !== 8'h00) begin n_fail++; $display("FAIL lost_clr got=%h exp=%h", irq_lost, 8'h00); end
    irq_in = 8'h00;
    cycles(2);
    irq_in = 8'h08;
    cycles(2);
    pulse_ctrl(8'h08, 8'h00);
    n_checks++; if (pending !== 8'h08) begin n_fail++; $display("FAIL simul_pending got=%h exp=%h", pending, 8'h08); end
    n_checks++; if (in_service !== 8'h08) begin n_fail++; $display("FAIL simul_in_service got=%h exp=%h", in_service, 8'h08); end
    n_checks++; if (irq_lost !== 8'h00) begin n_fail++; $display("FAIL simul_lost got=%h exp=%h", irq_lost, 8'h00); end
  endtask

  task automatic test_reset_mid_service();
    pulse_ctrl(8'h08, 8'h00);
    pulse_ctrl(8'h05, 8'h08);
    irq_in = 8'h80;
    cycles(3);
    n_checks++; if (in_service !== 8'h05) begin n_fail++; $display("FAIL mid_in_service got=%h exp=%h", in_service, 8'h05); end
    n_checks++; if (pending !== 8'h80) begin n_fail++; $display("FAIL mid_pending got=%h exp=%h", pending, 8'h80); end
    n_checks++; if (min_bit_a !== 8'h01) begin n_fail++; $display("FAIL mid_min_a got=%h exp=%h", min_bit_a, 8'h01); end
    n_checks++; if (min_bit_s !== 8'h80) begin n_fail++; $display("FAIL mid_min_s got=%h exp=%h", min_bit_s, 8'h80); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (pending !== 8'h00) begin n_fail++; $display("FAIL arst_pending got=%h exp=%h", pending, 8'h00); end
    n_checks++; if (in_service !== 8'h00) begin n_fail++; $display("FAIL arst_in_service got=%h exp=%h", in_service, 8'h00); end
    n_checks++; if (irq_lost !== 8'h00) begin n_fail++; $display("FAIL arst_irq_lost got=%h exp=%h", irq_lost, 8'h00); end
    n_checks++; if (min_bit_s !== 8'h00) begin n_fail++; $display("FAIL arst_min_s got=%h exp=%h", min_bit_s, 8'h00); end
    n_checks++; if (min_bit_a !== 8'h00) begin n_fail++; $display("FAIL arst_min_a got=%h exp=%h", min_bit_a, 8'h00); end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b0;
    irq_in        = 8'h00;
    irq_mask      = 8'hFF;
    s_intr        = 1'b0;
    s_call_intr   = 8'h00;
    s_return_intr = 8'h00;
    lost_clr      = 1'b0;

    test_reset();
    test_latency();
    test_ack();
    test_nesting();
    test_mask();
    test_lost();
    test_reset_mid_service();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
